// File: rtl/npu_dma_pkg.sv
// Shared types for the NPU DMA descriptor queue: descriptor layout, opcodes,
// completion status codes and issue-sequencer state encoding.
package npu_dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_TAG_W  = 4;
    localparam int DMA_SIZE_W = 22;

    typedef enum logic [2:0] {
        OP_MEM2REG = 3'b000,
        OP_REG2MEM = 3'b001,
        OP_MEM2MEM = 3'b010
    } dma_op_t;

    typedef enum logic [1:0] {
        CPL_OK      = 2'b00,
        CPL_DMA_ERR = 2'b01,
        CPL_TIMEOUT = 2'b10,
        CPL_INVALID = 2'b11
    } dma_cpl_status_t;

    typedef logic [1:0] qstate_t;
    localparam qstate_t ST_IDLE   = 2'd0;
    localparam qstate_t ST_ISSUE  = 2'd1;
    localparam qstate_t ST_WAIT   = 2'd2;
    localparam qstate_t ST_RETIRE = 2'd3;

    // op is kept as raw bits so out-of-range opcodes survive to the validity check
    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src;
        logic [DMA_ADDR_W-1:0] dst;
        logic [DMA_SIZE_W-1:0] size;
        logic [2:0]            op;
        logic [DMA_TAG_W-1:0]  tag;
    } dma_desc_t;

    function automatic logic desc_is_valid(input dma_desc_t d);
        return (d.size != '0) && (d.op <= OP_MEM2MEM);
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; head word visible on pop_data.
// Pushes while full and pops while empty are ignored; flush beats push and pop.
module npu_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LEVEL);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/npu_dma_desc_queue.sv
// Descriptor queue + one-at-a-time DMA issue sequencer; push to dma_req is 2 cycles when idle.
// desc_ready drops when full or flushing; completion record held until cpl_ready_i.
module npu_dma_desc_queue
    import npu_dma_pkg::*;
#(
    parameter  int DEPTH          = 8,
    parameter  int ADDR_WIDTH     = DMA_ADDR_W,
    parameter  int TAG_WIDTH      = DMA_TAG_W,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int LW             = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [ADDR_WIDTH-1:0] desc_src_i,
    input  logic [ADDR_WIDTH-1:0] desc_dst_i,
    input  logic [21:0]           desc_size_i,
    input  logic [2:0]            desc_op_i,
    input  logic [TAG_WIDTH-1:0]  desc_tag_i,
    output logic                  dma_req_o,
    output logic [ADDR_WIDTH-1:0] dma_src_addr_o,
    output logic [ADDR_WIDTH-1:0] dma_dst_addr_o,
    output logic [21:0]           dma_size_o,
    output logic [2:0]            dma_op_o,
    input  logic                  dma_done_i,
    input  logic                  dma_error_i,
    output logic                  cpl_valid_o,
    input  logic                  cpl_ready_i,
    output logic [TAG_WIDTH-1:0]  cpl_tag_o,
    output logic [1:0]            cpl_status_o,
    output logic                  busy_o,
    output logic [LW-1:0]         level_o
);

    localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W   = (WD_RAW > 12) ? WD_RAW : 12;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    dma_desc_t       push_desc;
    dma_desc_t       fifo_head;
    dma_desc_t       issue_q;
    dma_cpl_status_t status_q;
    qstate_t         state;
    logic [WD_W-1:0] wdog;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;

    always_comb begin
        push_desc      = '0;
        push_desc.src  = DMA_ADDR_W'(desc_src_i);
        push_desc.dst  = DMA_ADDR_W'(desc_dst_i);
        push_desc.size = desc_size_i;
        push_desc.op   = desc_op_i;
        push_desc.tag  = DMA_TAG_W'(desc_tag_i);
    end

    // Ready is also masked while reset is held so every output reads 0 in reset
    assign desc_ready_o = !fifo_full && !flush_i && !rst_i;
    assign fifo_push    = desc_valid_i && desc_ready_o;
    assign fifo_pop     = (state == ST_IDLE) && !fifo_empty && !flush_i;

    npu_sync_fifo #(
        .WIDTH ($bits(dma_desc_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush_i),
        .push      (fifo_push),
        .push_data (push_desc),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            issue_q  <= '0;
            status_q <= CPL_OK;
            wdog     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        issue_q <= fifo_head;
                        if (desc_is_valid(fifo_head)) begin
                            state <= ST_ISSUE;
                        end else begin
                            state    <= ST_RETIRE;
                            status_q <= CPL_INVALID;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    wdog  <= '0;
                end
                ST_WAIT: begin
                    if (wdog != '1) wdog <= wdog + WD_W'(1);
                    // Error outranks a coincident done
                    if (dma_error_i) begin
                        state    <= ST_RETIRE;
                        status_q <= CPL_DMA_ERR;
                    end else if (dma_done_i) begin
                        state    <= ST_RETIRE;
                        status_q <= CPL_OK;
                    end else if ((TIMEOUT_CYCLES != 0) && (wdog == WD_LAST)) begin
                        state    <= ST_RETIRE;
                        status_q <= CPL_TIMEOUT;
                    end
                end
                ST_RETIRE: begin
                    if (cpl_ready_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dma_req_o      = (state == ST_ISSUE);
    assign dma_src_addr_o = ADDR_WIDTH'(issue_q.src);
    assign dma_dst_addr_o = ADDR_WIDTH'(issue_q.dst);
    assign dma_size_o     = issue_q.size;
    assign dma_op_o       = issue_q.op;
    assign cpl_valid_o    = (state == ST_RETIRE);
    assign cpl_tag_o      = TAG_WIDTH'(issue_q.tag);
    assign cpl_status_o   = status_q;
    assign busy_o         = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_npu_dma_desc_queue.sv
// Directed scenarios plus randomized traffic against an in-order queue reference model.
`timescale 1ns/1ps
module tb_npu_dma_desc_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        desc_valid = 1'b0;
    logic [31:0] desc_src = '0;
    logic [31:0] desc_dst = '0;
    logic [21:0] desc_size = '0;
    logic [2:0]  desc_op = '0;
    logic [3:0]  desc_tag = '0;
    logic        dma_done = 1'b0;
    logic        dma_error = 1'b0;
    logic        cpl_ready = 1'b0;

    logic        desc_ready, dma_req, cpl_valid, busy;
    logic [31:0] dma_src, dma_dst;
    logic [21:0] dma_size;
    logic [2:0]  dma_op;
    logic [3:0]  cpl_tag, level;
    logic [1:0]  cpl_status;

    logic        t_desc_ready, t_dma_req, t_cpl_valid, t_busy;
    logic [31:0] t_dma_src, t_dma_dst;
    logic [21:0] t_dma_size;
    logic [2:0]  t_dma_op;
    logic [3:0]  t_cpl_tag, t_level;
    logic [1:0]  t_cpl_status;

    always #5 clk = ~clk;

    npu_dma_desc_queue #(.DEPTH(8), .ADDR_WIDTH(32), .TAG_WIDTH(4), .TIMEOUT_CYCLES(4096)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_src_i(desc_src), .desc_dst_i(desc_dst), .desc_size_i(desc_size),
        .desc_op_i(desc_op), .desc_tag_i(desc_tag),
        .dma_req_o(dma_req), .dma_src_addr_o(dma_src), .dma_dst_addr_o(dma_dst),
        .dma_size_o(dma_size), .dma_op_o(dma_op),
        .dma_done_i(dma_done), .dma_error_i(dma_error),
        .cpl_valid_o(cpl_valid), .cpl_ready_i(cpl_ready), .cpl_tag_o(cpl_tag),
        .cpl_status_o(cpl_status), .busy_o(busy), .level_o(level)
    );

    // Short-watchdog instance shares all stimulus; only examined in the timeout scenario
    npu_dma_desc_queue #(.DEPTH(8), .ADDR_WIDTH(32), .TAG_WIDTH(4), .TIMEOUT_CYCLES(16)) dut_to (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .desc_valid_i(desc_valid), .desc_ready_o(t_desc_ready),
        .desc_src_i(desc_src), .desc_dst_i(desc_dst), .desc_size_i(desc_size),
        .desc_op_i(desc_op), .desc_tag_i(desc_tag),
        .dma_req_o(t_dma_req), .dma_src_addr_o(t_dma_src), .dma_dst_addr_o(t_dma_dst),
        .dma_size_o(t_dma_size), .dma_op_o(t_dma_op),
        .dma_done_i(dma_done), .dma_error_i(dma_error),
        .cpl_valid_o(t_cpl_valid), .cpl_ready_i(cpl_ready), .cpl_tag_o(t_cpl_tag),
        .cpl_status_o(t_cpl_status), .busy_o(t_busy), .level_o(t_level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; desc_valid = 1'b0; flush = 1'b0;
        dma_done = 1'b0; dma_error = 1'b0; cpl_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Returns one cycle after the accepting edge
    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [21:0] sz,
                             input logic [2:0] op, input logic [3:0] tg);
        int g;
        g = 0;
        desc_src = s; desc_dst = d; desc_size = sz; desc_op = op; desc_tag = tg;
        desc_valid = 1'b1;
        while (!desc_ready && g < 100) begin
            tick();
            g++;
        end
        chk_eq("push_ready", desc_ready, 1'b1);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic serve(input logic [3:0] tg, input logic [1:0] st, input bit dn, input bit er,
                         input int hold, input bit wait_req);
        int g;
        int reqs;
        reqs = 0;
        cpl_ready = 1'b0;
        if (wait_req) begin
            g = 0;
            while (!dma_req && g < 200) begin
                tick();
                g++;
            end
            chk_eq("req_seen", dma_req, 1'b1);
            tick();
        end
        if (dn || er) begin
            dma_done = dn; dma_error = er;
            tick();
            dma_done = 1'b0; dma_error = 1'b0;
        end
        g = 0;
        while (!cpl_valid && g < 200) begin
            if (dma_req) reqs++;
            tick();
            g++;
        end
        chk_eq("cpl_valid", cpl_valid, 1'b1);
        chk_eq("cpl_tag", cpl_tag, tg);
        chk_eq("cpl_status", cpl_status, st);
        if (!(dn || er)) chk_eq("invalid_no_req", reqs, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk_eq("hold_valid", cpl_valid, 1'b1);
            chk_eq("hold_tag", cpl_tag, tg);
            chk_eq("hold_status", cpl_status, st);
        end
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
    endtask

    // Reference model: in-order list of accepted descriptors
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [21:0] size;
        logic [2:0]  op;
        logic [3:0]  tag;
    } ref_desc_t;

    ref_desc_t   model_q[$];
    ref_desc_t   mon_exp;
    logic [1:0]  resp_status = 2'b00;
    bit          rnd_on = 1'b0;
    bit          outstanding = 1'b0;
    int          n_cpl = 0;

    function automatic bit ref_ok(input ref_desc_t d);
        return (d.size != 0) && (d.op inside {3'b000, 3'b001, 3'b010});
    endfunction

    always @(negedge clk) begin
        if (rnd_on && !rst) begin
            if (desc_valid && desc_ready)
                model_q.push_back('{src: desc_src, dst: desc_dst, size: desc_size, op: desc_op, tag: desc_tag});
            if (dma_req) begin
                chk_eq("rnd_single_outstanding", outstanding, 1'b0);
                if (model_q.size() == 0) begin
                    chk_eq("rnd_unexpected_req", dma_req, 1'b0);
                end else begin
                    chk_eq("rnd_req_src", dma_src, model_q[0].src);
                    chk_eq("rnd_req_dst", dma_dst, model_q[0].dst);
                    chk_eq("rnd_req_size", dma_size, model_q[0].size);
                    chk_eq("rnd_req_op", dma_op, model_q[0].op);
                    chk_eq("rnd_req_of_valid_desc", ref_ok(model_q[0]), 1'b1);
                end
                outstanding = 1'b1;
            end
            if (cpl_valid && cpl_ready) begin
                if (model_q.size() == 0) begin
                    chk_eq("rnd_unexpected_cpl", cpl_valid, 1'b0);
                end else begin
                    mon_exp = model_q.pop_front();
                    chk_eq("rnd_cpl_tag", cpl_tag, mon_exp.tag);
                    chk_eq("rnd_cpl_status", cpl_status, ref_ok(mon_exp) ? resp_status : 2'b11);
                end
                outstanding = 1'b0;
                n_cpl++;
            end
        end
    end

    task automatic pusher(input int n);
        int acc;
        int g;
        acc = 0;
        g = 0;
        while (acc < n && g < 20000) begin
            @(posedge clk); #1;
            g++;
            desc_valid = ($urandom_range(0, 2) != 0);
            desc_src   = $urandom;
            desc_dst   = $urandom;
            desc_size  = ($urandom_range(0, 7) == 0) ? 22'd0 : 22'($urandom);
            desc_op    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            desc_tag   = 4'($urandom);
            @(negedge clk);
            if (desc_valid && desc_ready) acc++;
        end
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic responder();
        int d;
        int k;
        while (rnd_on) begin
            @(negedge clk);
            if (dma_req) begin
                d = $urandom_range(1, 24);
                k = $urandom_range(0, 3);
                repeat (d) @(posedge clk);
                #1;
                dma_done    = (k != 1);
                dma_error   = (k == 1) || (k == 2);
                resp_status = dma_error ? 2'b01 : 2'b00;
                @(posedge clk); #1;
                dma_done = 1'b0; dma_error = 1'b0;
            end
        end
    endtask

    task automatic rdy_driver();
        while (rnd_on) begin
            @(posedge clk); #1;
            cpl_ready = ($urandom_range(0, 2) != 0);
        end
        cpl_ready = 1'b0;
    endtask

    initial begin
        int g;
        int cnt;
        int reqs;

        // Reset values while reset is held
        tick();
        chk_eq("rst_ready", desc_ready, 1'b0);
        chk_eq("rst_req", dma_req, 1'b0);
        chk_eq("rst_cpl_valid", cpl_valid, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_level", level, 4'd0);
        chk_eq("rst_src", dma_src, 32'd0);
        chk_eq("rst_status", cpl_status, 2'd0);
        rst = 1'b0;
        tick();
        chk_eq("post_rst_ready", desc_ready, 1'b1);

        // Single transfer: req two cycles after push, done 20 cycles after req
        push_desc(32'h1000, 32'h2000, 22'd256, 3'b010, 4'd3);
        chk_eq("lat_n1_no_req", dma_req, 1'b0);
        tick();
        chk_eq("lat_n2_req", dma_req, 1'b1);
        chk_eq("req_src", dma_src, 32'h1000);
        chk_eq("req_dst", dma_dst, 32'h2000);
        chk_eq("req_size", dma_size, 22'd256);
        chk_eq("req_op", dma_op, 3'b010);
        tick();
        chk_eq("req_one_cycle", dma_req, 1'b0);
        repeat (19) tick();
        chk_eq("no_early_cpl", cpl_valid, 1'b0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk_eq("t1_cpl_valid", cpl_valid, 1'b1);
        chk_eq("t1_cpl_tag", cpl_tag, 4'd3);
        chk_eq("t1_cpl_status", cpl_status, 2'b00);
        chk_eq("t1_src_held", dma_src, 32'h1000);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk_eq("t1_cpl_done", cpl_valid, 1'b0);
        chk_eq("t1_idle", busy, 1'b0);

        // Fill: one in flight plus eight queued
        do_reset();
        for (int i = 0; i < 9; i++)
            push_desc(32'h100 * i, 32'h8000 + i, 22'd64 + 22'(i), 3'(i % 3), 4'(i));
        chk_eq("full_level", level, 4'd8);
        chk_eq("full_not_ready", desc_ready, 1'b0);
        desc_valid = 1'b1; desc_tag = 4'hF;
        tick();
        desc_valid = 1'b0;
        chk_eq("full_push_dropped", level, 4'd8);
        serve(4'd0, 2'b00, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 1; i < 9; i++)
            serve(4'(i), 2'b00, 1'b1, 1'b0, 0, 1'b1);
        chk_eq("fill_drained", busy, 1'b0);

        // Invalid descriptors retire without a request
        push_desc(32'h10, 32'h20, 22'd0, 3'b010, 4'd5);
        serve(4'd5, 2'b11, 1'b0, 1'b0, 0, 1'b0);
        push_desc(32'h10, 32'h20, 22'd16, 3'b101, 4'd6);
        serve(4'd6, 2'b11, 1'b0, 1'b0, 0, 1'b0);

        // Done and error together, completion back-pressured for 5 cycles
        push_desc(32'h30, 32'h40, 22'd8, 3'b000, 4'd8);
        serve(4'd8, 2'b01, 1'b1, 1'b1, 5, 1'b1);

        // Flush with three queued and one waiting
        do_reset();
        for (int i = 0; i < 4; i++)
            push_desc(32'h500 + i, 32'h600 + i, 22'd32, 3'b001, 4'(10 + i));
        chk_eq("pre_flush_level", level, 4'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_eq("flush_level", level, 4'd0);
        chk_eq("flush_busy_inflight", busy, 1'b1);
        serve(4'd10, 2'b00, 1'b1, 1'b0, 0, 1'b0);
        cnt = 0;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpl_valid) cnt++;
            if (dma_req) reqs++;
            tick();
        end
        chk_eq("flush_no_more_cpl", cnt, 0);
        chk_eq("flush_no_more_req", reqs, 0);
        chk_eq("flush_idle", busy, 1'b0);

        // Reset while waiting discards the transfer
        push_desc(32'h700, 32'h800, 22'd12, 3'b010, 4'd7);
        g = 0;
        while (!dma_req && g < 50) begin tick(); g++; end
        chk_eq("wrst_req", dma_req, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_eq("wrst_cpl_valid", cpl_valid, 1'b0);
        chk_eq("wrst_busy", busy, 1'b0);
        chk_eq("wrst_src", dma_src, 32'd0);
        chk_eq("wrst_size", dma_size, 22'd0);
        chk_eq("wrst_tag", cpl_tag, 4'd0);
        chk_eq("wrst_ready", desc_ready, 1'b0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpl_valid) cnt++;
            tick();
        end
        chk_eq("wrst_no_cpl", cnt, 0);
        chk_eq("wrst_idle", busy, 1'b0);

        // Watchdog of 16: fires on the 16th WAIT cycle (req+16), record visible from req+17
        do_reset();
        push_desc(32'h900, 32'hA00, 22'd64, 3'b000, 4'd9);
        g = 0;
        while (!t_dma_req && g < 50) begin tick(); g++; end
        chk_eq("to_req", t_dma_req, 1'b1);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!t_cpl_valid && cnt < 100);
        chk_eq("to_cpl_cycle", cnt, 17);
        chk_eq("to_cpl_status", t_cpl_status, 2'b10);
        chk_eq("to_cpl_tag", t_cpl_tag, 4'd9);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk_eq("to_late_done_ignored", t_cpl_status, 2'b10);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (t_cpl_valid) cnt++;
            tick();
        end
        chk_eq("to_single_cpl", cnt, 0);
        chk_eq("to_idle", t_busy, 1'b0);

        // Randomized traffic against the reference model
        do_reset();
        model_q.delete();
        outstanding = 1'b0;
        n_cpl = 0;
        rnd_on = 1'b1;
        fork
            begin
                pusher(60);
                g = 0;
                while (model_q.size() != 0 && g < 5000) begin
                    @(posedge clk);
                    g++;
                end
                rnd_on = 1'b0;
            end
            responder();
            rdy_driver();
        join
        chk_eq("rnd_drained", model_q.size(), 0);
        chk_eq("rnd_cpl_count", n_cpl, 60);
        tick();
        chk_eq("rnd_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
